// File: rtl/posicionador_de_navios_if.sv
// rtl/posicionador_de_navios_if.sv - cursor/button inputs and board outputs of the ship placer
interface posicionador_de_navios_if #(
    parameter int CONT_W = 3
);
    logic              enable;
    logic [2:0]        coordColuna;
    logic [2:0]        coordLinha;
    logic              confirmar;
    logic              apagar;
    logic [6:0]        mapa0;
    logic [6:0]        mapa1;
    logic [6:0]        mapa2;
    logic [6:0]        mapa3;
    logic [6:0]        mapa4;
    logic [CONT_W-1:0] restantes;
    logic              pronto;
    logic              LED_R;
    logic              LED_G;
    logic              LED_B;

    modport master (
        output enable, coordColuna, coordLinha, confirmar, apagar,
        input  mapa0, mapa1, mapa2, mapa3, mapa4, restantes, pronto, LED_R, LED_G, LED_B
    );

    modport slave (
        input  enable, coordColuna, coordLinha, confirmar, apagar,
        output mapa0, mapa1, mapa2, mapa3, mapa4, restantes, pronto, LED_R, LED_G, LED_B
    );
endinterface

// File: rtl/posicionador_de_navios.sv
// rtl/posicionador_de_navios.sv - places/removes ship cells on a 5x7 board with a cell budget
module posicionador_de_navios #(
    parameter int NUM_CELULAS = 6,
    parameter int CONT_W      = 3
) (
    input logic                     clock,
    input logic                     reset,
    posicionador_de_navios_if.slave bus
);
    typedef enum logic [1:0] {OCIOSO, POSICIONANDO, PRONTO} estado_t;

    estado_t                estado_q, estado_d;
    logic [4:0][6:0]        mapa_q, mapa_d;
    logic [CONT_W-1:0]      rest_q, rest_d;
    logic                   pronto_q, pronto_d;
    logic                   led_r_q, led_r_d;
    logic                   led_g_q, led_g_d;
    logic                   conf_q;

    logic       evento;
    logic       coord_ok;
    logic       ocupada;
    logic [2:0] col;
    logic [2:0] lin;

    assign col      = bus.coordColuna;
    assign lin      = bus.coordLinha;
    assign evento   = bus.confirmar & ~conf_q;
    assign coord_ok = (col <= 3'd4) && (lin <= 3'd6);
    assign ocupada  = coord_ok && mapa_q[col][lin];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= OCIOSO;
            mapa_q   <= '0;
            rest_q   <= CONT_W'(NUM_CELULAS);
            pronto_q <= 1'b0;
            led_r_q  <= 1'b0;
            led_g_q  <= 1'b0;
            conf_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            mapa_q   <= mapa_d;
            rest_q   <= rest_d;
            pronto_q <= pronto_d;
            led_r_q  <= led_r_d;
            led_g_q  <= led_g_d;
            conf_q   <= bus.confirmar;
        end
    end

    always_comb begin
        estado_d = estado_q;
        mapa_d   = mapa_q;
        rest_d   = rest_q;
        pronto_d = pronto_q;
        led_r_d  = led_r_q;
        led_g_d  = led_g_q;

        // enable low overrides any button event in the same cycle
        if (!bus.enable) begin
            estado_d = OCIOSO;
            mapa_d   = '0;
            rest_d   = CONT_W'(NUM_CELULAS);
            pronto_d = 1'b0;
            led_r_d  = 1'b0;
            led_g_d  = 1'b0;
        end else begin
            case (estado_q)
                OCIOSO: estado_d = POSICIONANDO;
                POSICIONANDO: begin
                    if (evento) begin
                        led_r_d = 1'b1;
                        led_g_d = 1'b0;
                        if (coord_ok && !bus.apagar && !ocupada && rest_q != '0) begin
                            mapa_d[col][lin] = 1'b1;
                            rest_d  = rest_q - CONT_W'(1);
                            led_r_d = 1'b0;
                            led_g_d = 1'b1;
                            if (rest_q == CONT_W'(1)) begin
                                estado_d = PRONTO;
                                pronto_d = 1'b1;
                            end
                        end else if (bus.apagar && ocupada) begin
                            mapa_d[col][lin] = 1'b0;
                            rest_d  = rest_q + CONT_W'(1);
                            led_r_d = 1'b0;
                            led_g_d = 1'b1;
                        end
                    end
                end
                PRONTO: begin
                    if (evento) begin
                        led_r_d = 1'b1;
                        led_g_d = 1'b0;
                        if (bus.apagar && ocupada) begin
                            mapa_d[col][lin] = 1'b0;
                            rest_d   = CONT_W'(1);
                            pronto_d = 1'b0;
                            estado_d = POSICIONANDO;
                            led_r_d  = 1'b0;
                            led_g_d  = 1'b1;
                        end
                    end
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    assign bus.mapa0     = mapa_q[0];
    assign bus.mapa1     = mapa_q[1];
    assign bus.mapa2     = mapa_q[2];
    assign bus.mapa3     = mapa_q[3];
    assign bus.mapa4     = mapa_q[4];
    assign bus.restantes = rest_q;
    assign bus.pronto    = pronto_q;
    assign bus.LED_R     = led_r_q;
    assign bus.LED_G     = led_g_q;
    assign bus.LED_B     = pronto_q;
endmodule

// File: tb/tb_posicionador_de_navios.sv
// tb/tb_posicionador_de_navios.sv - self-checking bench with a board-level reference model
module tb_posicionador_de_navios;
    localparam int NUM = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    posicionador_de_navios_if #(.CONT_W(3)) bus ();

    posicionador_de_navios #(.NUM_CELULAS(NUM), .CONT_W(3)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // reference model: the board as a plain array plus a count of cells left
    bit m_board[5][7];
    int m_rest;
    bit m_led_r, m_led_g;
    bit m_active;
    bit m_prev;

    task automatic m_clear();
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 7; r++) m_board[c][r] = 1'b0;
        m_rest  = NUM;
        m_led_r = 1'b0;
        m_led_g = 1'b0;
    endtask

    task automatic m_event(input int c, input int r, input bit del);
        bit ok;
        ok = 1'b0;
        if (c <= 4 && r <= 6) begin
            if (!del && !m_board[c][r] && m_rest > 0) begin
                m_board[c][r] = 1'b1;
                m_rest--;
                ok = 1'b1;
            end else if (del && m_board[c][r]) begin
                m_board[c][r] = 1'b0;
                m_rest++;
                ok = 1'b1;
            end
        end
        m_led_g = ok;
        m_led_r = !ok;
    endtask

    function automatic logic [6:0] col_bits(input int c);
        logic [6:0] v;
        for (int r = 0; r < 7; r++) v[r] = m_board[c][r];
        return v;
    endfunction

    always @(posedge clock or negedge reset) begin
        bit ev;
        if (!reset) begin
            m_clear();
            m_active = 1'b0;
            m_prev   = 1'b0;
        end else begin
            ev     = bus.confirmar && !m_prev;
            m_prev = bus.confirmar;
            if (!bus.enable) begin
                m_clear();
                m_active = 1'b0;
            end else begin
                if (m_active && ev) m_event(int'(bus.coordColuna), int'(bus.coordLinha), bus.apagar);
                m_active = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    bit cmp_en = 1'b0;

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("mapa0", int'(bus.mapa0), int'(col_bits(0)));
            chk("mapa1", int'(bus.mapa1), int'(col_bits(1)));
            chk("mapa2", int'(bus.mapa2), int'(col_bits(2)));
            chk("mapa3", int'(bus.mapa3), int'(col_bits(3)));
            chk("mapa4", int'(bus.mapa4), int'(col_bits(4)));
            chk("restantes", int'(bus.restantes), m_rest);
            chk("pronto", int'(bus.pronto), int'(m_rest == 0));
            chk("LED_B", int'(bus.LED_B), int'(m_rest == 0));
            chk("LED_R", int'(bus.LED_R), int'(m_led_r));
            chk("LED_G", int'(bus.LED_G), int'(m_led_g));
        end
    end

    task automatic pulse(input int c, input int r, input bit del);
        bus.coordColuna = 3'(c);
        bus.coordLinha  = 3'(r);
        bus.apagar      = del;
        bus.confirmar   = 1'b1;
        @(negedge clock);
        bus.confirmar = 1'b0;
        @(negedge clock);
    endtask

    task automatic chk_map(input string tag, input logic [34:0] exp);
        chk({tag, "_m0"}, int'(bus.mapa0), int'(exp[6:0]));
        chk({tag, "_m1"}, int'(bus.mapa1), int'(exp[13:7]));
        chk({tag, "_m2"}, int'(bus.mapa2), int'(exp[20:14]));
        chk({tag, "_m3"}, int'(bus.mapa3), int'(exp[27:21]));
        chk({tag, "_m4"}, int'(bus.mapa4), int'(exp[34:28]));
    endtask

    initial begin
        bus.enable      = 1'b0;
        bus.coordColuna = 3'd0;
        bus.coordLinha  = 3'd0;
        bus.confirmar   = 1'b0;
        bus.apagar      = 1'b0;
        repeat (2) @(negedge clock);
        chk_map("rst", 35'd0);
        chk("rst_rest", int'(bus.restantes), 6);
        chk("rst_leds", int'({bus.pronto, bus.LED_R, bus.LED_G, bus.LED_B}), 0);
        reset  = 1'b1;
        cmp_en = 1'b1;
        bus.enable = 1'b1;
        @(negedge clock);

        pulse(0, 0, 0);
        pulse(0, 1, 0);
        pulse(0, 0, 0);
        chk("dup_led_r", int'(bus.LED_R), 1);
        chk("dup_led_g", int'(bus.LED_G), 0);
        chk("dup_rest", int'(bus.restantes), 4);
        chk("dup_m0", int'(bus.mapa0), 3);
        pulse(1, 5, 0);
        pulse(3, 5, 0);
        pulse(4, 6, 0);
        pulse(4, 0, 0);
        chk_map("full", {7'b1000001, 7'b0100000, 7'b0000000, 7'b0100000, 7'b0000011});
        chk("full_rest", int'(bus.restantes), 0);
        chk("full_pronto", int'(bus.pronto), 1);
        chk("full_ledb", int'(bus.LED_B), 1);
        chk("full_ledg", int'(bus.LED_G), 1);

        pulse(2, 2, 0);
        chk("pronto_rej", int'(bus.LED_R), 1);
        pulse(1, 5, 1);
        chk("del_m1", int'(bus.mapa1), 0);
        chk("del_rest", int'(bus.restantes), 1);
        chk("del_pronto", int'(bus.pronto), 0);
        pulse(2, 3, 0);
        chk("re_m2", int'(bus.mapa2), 7'b0001000);
        chk("re_pronto", int'(bus.pronto), 1);

        bus.enable = 1'b0;
        bus.confirmar = 1'b1;
        @(negedge clock);
        bus.confirmar = 1'b0;
        chk_map("dis", 35'd0);
        chk("dis_rest", int'(bus.restantes), 6);
        chk("dis_leds", int'({bus.pronto, bus.LED_R, bus.LED_G}), 0);
        bus.enable = 1'b1;
        @(negedge clock);

        pulse(5, 2, 0);
        chk("inv1_r", int'(bus.LED_R), 1);
        pulse(2, 7, 0);
        chk("inv2_r", int'(bus.LED_R), 1);
        chk_map("inv", 35'd0);
        chk("inv_rest", int'(bus.restantes), 6);

        bus.coordColuna = 3'd2;
        bus.coordLinha  = 3'd2;
        bus.apagar      = 1'b0;
        bus.confirmar   = 1'b1;
        repeat (10) @(negedge clock);
        bus.confirmar = 1'b0;
        @(negedge clock);
        chk("hold_rest", int'(bus.restantes), 5);

        pulse(0, 6, 0);
        pulse(4, 4, 0);
        chk("pre_rst_rest", int'(bus.restantes), 3);
        #2 reset = 1'b0;
        #1;
        chk_map("arst", 35'd0);
        chk("arst_rest", int'(bus.restantes), 6);
        bus.confirmar = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        bus.confirmar = 1'b0;
        @(negedge clock);
        chk("held_rest", int'(bus.restantes), 6);

        for (int i = 0; i < 400; i++) begin
            bus.enable      = ($urandom_range(0, 39) != 0);
            bus.coordColuna = 3'($urandom_range(0, 7));
            bus.coordLinha  = 3'($urandom_range(0, 7));
            bus.apagar      = ($urandom_range(0, 9) < 3);
            bus.confirmar   = 1'($urandom_range(0, 1));
            @(negedge clock);
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
